// File: rtl/sad_trigger_pkg.sv
// Shared types and constants for the SAD trigger controller.
package sad_trigger_pkg;

  localparam int SCORE_WIDTH_DEF   = 32;
  localparam int HOLDOFF_WIDTH_DEF = 16;
  localparam int COUNT_WIDTH_DEF   = 8;

  localparam logic [SCORE_WIDTH_DEF-1:0] SCORE_NONE = '1;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    FIRE,
    HOLDOFF,
    DONE
  } trig_state_e;

  // A programmed width of zero still produces a one-cycle pulse.
  function automatic logic [3:0] effective_width(input logic [3:0] w);
    return (w == 4'd0) ? 4'd1 : w;
  endfunction

endpackage

// File: rtl/sad_sat_counter.sv
// Saturating up-counter; clear takes priority over increment.
module sad_sat_counter #(
  parameter int pWIDTH = 8
) (
  input  logic              clk_adc,
  input  logic              reset,
  input  logic              inc,
  input  logic              clear,
  output logic [pWIDTH-1:0] count
);

  always_ff @(posedge clk_adc) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != {pWIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sad_trigger_ctrl.sv
// Qualifies raw SAD match strobes into capture triggers with arming,
// pulse width, holdoff and status tracking.
module sad_trigger_ctrl
  import sad_trigger_pkg::*;
#(
  parameter int pSCORE_WIDTH   = SCORE_WIDTH_DEF,
  parameter int pHOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF,
  parameter int pCOUNT_WIDTH   = COUNT_WIDTH_DEF
) (
  input  logic                      clk_adc,
  input  logic                      reset,
  input  logic                      armed_and_ready,
  input  logic                      sad_match,
  input  logic [pSCORE_WIDTH-1:0]   sad_score,
  input  logic                      multiple_triggers,
  input  logic [3:0]                trig_width,
  input  logic [pHOLDOFF_WIDTH-1:0] holdoff_cycles,
  input  logic                      status_clear,
  output logic                      trigger,
  output logic                      triggered,
  output logic [pCOUNT_WIDTH-1:0]   num_triggers,
  output logic [pCOUNT_WIDTH-1:0]   num_missed,
  output logic [pSCORE_WIDTH-1:0]   min_score,
  output logic                      busy
);

  trig_state_e               state, next_state;
  logic [3:0]                pulse_cnt;
  logic [pHOLDOFF_WIDTH-1:0] hold_cnt;
  logic [pHOLDOFF_WIDTH-1:0] hold_len;
  logic                      accept;
  logic                      miss;
  logic                      pulse_done;
  logic                      hold_done;

  assign accept     = (state == ARMED) && armed_and_ready && sad_match;
  assign miss       = sad_match && ((state == FIRE) || (state == HOLDOFF) || (state == DONE));
  assign pulse_done = (pulse_cnt == 4'd0);
  assign hold_done  = (hold_cnt == '0);

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!armed_and_ready) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = ARMED;
        ARMED:   if (sad_match) next_state = FIRE;
        FIRE: begin
          if (pulse_done) begin
            if (hold_len != '0)         next_state = HOLDOFF;
            else if (multiple_triggers) next_state = ARMED;
            else                        next_state = DONE;
          end
        end
        HOLDOFF: if (hold_done) next_state = multiple_triggers ? ARMED : DONE;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    trigger = (state == FIRE);
    busy    = (state == FIRE) || (state == HOLDOFF);
  end

  // Width and holdoff are captured at acceptance so mid-pulse edits only affect the next trigger.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      pulse_cnt <= 4'd0;
      hold_cnt  <= '0;
      hold_len  <= '0;
    end else begin
      if (accept) begin
        pulse_cnt <= effective_width(trig_width) - 4'd1;
        hold_len  <= holdoff_cycles;
      end else if ((state == FIRE) && !pulse_done) begin
        pulse_cnt <= pulse_cnt - 4'd1;
      end
      if ((state == FIRE) && pulse_done) begin
        hold_cnt <= hold_len - 1'b1;
      end else if ((state == HOLDOFF) && !hold_done) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_adc) begin
    if (reset || status_clear) begin
      triggered <= 1'b0;
      min_score <= '1;
    end else if (accept) begin
      triggered <= 1'b1;
      if (sad_score < min_score) begin
        min_score <= sad_score;
      end
    end
  end

  sad_sat_counter #(.pWIDTH(pCOUNT_WIDTH)) u_trig_count (
    .clk_adc (clk_adc),
    .reset   (reset),
    .inc     (accept),
    .clear   (status_clear),
    .count   (num_triggers)
  );

  sad_sat_counter #(.pWIDTH(pCOUNT_WIDTH)) u_miss_count (
    .clk_adc (clk_adc),
    .reset   (reset),
    .inc     (miss),
    .clear   (status_clear),
    .count   (num_missed)
  );

endmodule

// File: tb/tb_sad_trigger_ctrl.sv
// Scoreboard bench: each accepted match queues the expected pulse, a monitor checks every rising trigger.
module tb_sad_trigger_ctrl;
  import sad_trigger_pkg::*;

  logic        clk_adc = 1'b0;
  logic        reset = 1'b1;
  logic        armed_and_ready = 1'b0;
  logic        sad_match = 1'b0;
  logic [31:0] sad_score = '0;
  logic        multiple_triggers = 1'b1;
  logic [3:0]  trig_width = 4'd1;
  logic [15:0] holdoff_cycles = '0;
  logic        status_clear = 1'b0;
  logic        trigger;
  logic        triggered;
  logic [7:0]  num_triggers;
  logic [7:0]  num_missed;
  logic [31:0] min_score;
  logic        busy;

  typedef struct {
    int          rise;
    int          width;
    int          ntrig;
    logic        trig;
    logic [31:0] minsc;
  } pulse_rec_t;

  pulse_rec_t sbQueue[$];
  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;

  sad_trigger_ctrl dut (
    .clk_adc           (clk_adc),
    .reset             (reset),
    .armed_and_ready   (armed_and_ready),
    .sad_match         (sad_match),
    .sad_score         (sad_score),
    .multiple_triggers (multiple_triggers),
    .trig_width        (trig_width),
    .holdoff_cycles    (holdoff_cycles),
    .status_clear      (status_clear),
    .trigger           (trigger),
    .triggered         (triggered),
    .num_triggers      (num_triggers),
    .num_missed        (num_missed),
    .min_score         (min_score),
    .busy              (busy)
  );

  always #5 clk_adc = ~clk_adc;
  always @(posedge clk_adc) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic arm, input logic match, input logic [31:0] score, input logic clr);
    armed_and_ready = arm;
    sad_match       = match;
    sad_score       = score;
    status_clear    = clr;
    @(negedge clk_adc);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic expectPulse(input int w, input int nt, input logic tr, input logic [31:0] ms);
    pulse_rec_t rec;
    rec.rise  = cycle + 1;
    rec.width = w;
    rec.ntrig = nt;
    rec.trig  = tr;
    rec.minsc = ms;
    sbQueue.push_back(rec);
  endtask

  task automatic checkResetState();
    checkOutput("rst_trigger", 32'(trigger), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_triggered", 32'(triggered), 32'd0);
    checkOutput("rst_num_triggers", 32'(num_triggers), 32'd0);
    checkOutput("rst_num_missed", 32'(num_missed), 32'd0);
    checkOutput("rst_min_score", min_score, SCORE_NONE);
  endtask

  // Monitor: pops one record per rising trigger and checks timing, status and final width.
  initial begin
    pulse_rec_t cur;
    logic prevTrig = 1'b0;
    bit   active = 1'b0;
    int   hiCount = 0;
    forever begin
      @(posedge clk_adc);
      #1;
      if (trigger && !prevTrig) begin
        hiCount = 1;
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_trigger", 32'd1, 32'd0);
          active = 1'b0;
        end else begin
          cur = sbQueue.pop_front();
          active = 1'b1;
          checkOutput("rise_cycle", 32'(cycle), 32'(cur.rise));
          checkOutput("pulse_num_triggers", 32'(num_triggers), 32'(cur.ntrig));
          checkOutput("pulse_triggered", 32'(triggered), 32'(cur.trig));
          checkOutput("pulse_min_score", min_score, cur.minsc);
          checkOutput("pulse_busy", 32'(busy), 32'd1);
        end
      end else if (trigger) begin
        hiCount++;
      end else if (prevTrig && active) begin
        checkOutput("pulse_width", 32'(hiCount), 32'(cur.width));
        active = 1'b0;
      end
      prevTrig = trigger;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk_adc);
    checkResetState();
    reset = 1'b0;

    // Basic fire: width 1, no holdoff
    multiple_triggers = 1'b1;
    trig_width        = 4'd1;
    holdoff_cycles    = 16'd0;
    idleCycles(2);
    expectPulse(1, 1, 1'b1, 32'd37);
    applyStimulus(1'b1, 1'b1, 32'd37, 1'b0);
    idleCycles(3);

    // Holdoff and missed: matches at relative cycles 0, 4 and 13
    trig_width     = 4'd4;
    holdoff_cycles = 16'd8;
    expectPulse(4, 2, 1'b1, 32'd37);
    applyStimulus(1'b1, 1'b1, 32'd50, 1'b0);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 32'd1, 1'b0);
    idleCycles(2);
    checkOutput("holdoff_busy", 32'(busy), 32'd1);
    checkOutput("holdoff_trigger", 32'(trigger), 32'd0);
    idleCycles(6);
    expectPulse(4, 3, 1'b1, 32'd20);
    applyStimulus(1'b1, 1'b1, 32'd20, 1'b0);
    idleCycles(14);
    checkOutput("holdoff_num_missed", 32'(num_missed), 32'd1);

    // Single mode: only the first of three matches fires
    multiple_triggers = 1'b0;
    trig_width        = 4'd2;
    holdoff_cycles    = 16'd3;
    expectPulse(2, 4, 1'b1, 32'd20);
    applyStimulus(1'b1, 1'b1, 32'd100, 1'b0);
    idleCycles(49);
    applyStimulus(1'b1, 1'b1, 32'd2, 1'b0);
    idleCycles(49);
    applyStimulus(1'b1, 1'b1, 32'd2, 1'b0);
    idleCycles(2);
    checkOutput("single_num_missed", 32'(num_missed), 32'd3);
    checkOutput("single_num_triggers", 32'(num_triggers), 32'd4);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    expectPulse(2, 5, 1'b1, 32'd5);
    applyStimulus(1'b1, 1'b1, 32'd5, 1'b0);
    idleCycles(10);
    checkOutput("rearm_num_triggers", 32'(num_triggers), 32'd5);

    // Disarm three cycles into a ten-cycle pulse
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    multiple_triggers = 1'b1;
    trig_width        = 4'd10;
    holdoff_cycles    = 16'd0;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    expectPulse(3, 6, 1'b1, 32'd5);
    applyStimulus(1'b1, 1'b1, 32'd9, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("disarm_trigger", 32'(trigger), 32'd0);
    checkOutput("disarm_busy", 32'(busy), 32'd0);
    checkOutput("disarm_num_triggers", 32'(num_triggers), 32'd6);
    applyStimulus(1'b0, 1'b1, 32'd9, 1'b0);
    checkOutput("disarm_idle_not_missed", 32'(num_missed), 32'd3);

    // Saturation of the trigger counter, then clear coinciding with a match
    trig_width = 4'd1;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      expectPulse(1, (7 + i > 255) ? 255 : 7 + i, 1'b1, 32'd5);
      applyStimulus(1'b1, 1'b1, 32'd1000, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    end
    checkOutput("sat_num_triggers", 32'(num_triggers), 32'd255);
    checkOutput("sat_min_score", min_score, 32'd5);
    expectPulse(1, 0, 1'b0, SCORE_NONE);
    applyStimulus(1'b1, 1'b1, 32'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("clear_num_triggers", 32'(num_triggers), 32'd0);
    checkOutput("clear_triggered", 32'(triggered), 32'd0);
    checkOutput("clear_min_score", min_score, SCORE_NONE);
    checkOutput("clear_num_missed", 32'(num_missed), 32'd0);

    // Reset during holdoff
    trig_width     = 4'd2;
    holdoff_cycles = 16'd10;
    expectPulse(2, 1, 1'b1, 32'd77);
    applyStimulus(1'b1, 1'b1, 32'd77, 1'b0);
    idleCycles(4);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    checkResetState();
    applyStimulus(1'b1, 1'b1, 32'd50, 1'b0);
    checkOutput("post_reset_idle_trigger", 32'(trigger), 32'd0);
    checkOutput("post_reset_idle_missed", 32'(num_missed), 32'd0);
    expectPulse(2, 1, 1'b1, 32'd44);
    applyStimulus(1'b1, 1'b1, 32'd44, 1'b0);
    idleCycles(15);

    checkOutput("scoreboard_empty", 32'(sbQueue.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sad_trigger_ctrl.md
Name: sad_trigger_ctrl

Overview:
- Downstream of the SAD comparison core.
- Takes the core's raw per-cycle match strobe and its SAD score, and turns them into the qualified trigger seen by the capture logic.
- Applies arming, single/multiple-trigger policy, a configurable output pulse width and a post-trigger holdoff.
- Keeps the status readable over USB: triggered flag, trigger count, missed-match count and best (minimum) score.

Parameters:
- pSCORE_WIDTH, 32: width of SAD score and threshold domain.
- pHOLDOFF_WIDTH, 16: width of holdoff cycle count.
- pCOUNT_WIDTH, 8: width of trigger and missed counters (saturating).

Ports:
- clk_adc  in  1  sole clock (ADC sample clock).
- reset  in  1  synchronous, active-high; one clock, sync active-high reset (fixed).
- armed_and_ready  in  1  capture armed; triggers only accepted while high.
- sad_match  in  1  raw match strobe from SAD core, one per matching window.
- sad_score  in  pSCORE_WIDTH  SAD value accompanying sad_match (valid only with it).
- multiple_triggers  in  1  1 = re-arm after holdoff; 0 = one trigger per arming.
- trig_width  in  4  output pulse width in cycles; 0 treated as 1.
- holdoff_cycles  in  pHOLDOFF_WIDTH  dead cycles after pulse; 0 = none.
- status_clear  in  1  single-cycle clear of status outputs.
- trigger  out  1  qualified trigger pulse (registered).
- triggered  out  1  sticky: at least one trigger since clear.
- num_triggers  out  pCOUNT_WIDTH  accepted triggers, saturating at all-ones.
- num_missed  out  pCOUNT_WIDTH  matches ignored while in FIRE/HOLDOFF/DONE, saturating.
- min_score  out  pSCORE_WIDTH  smallest sad_score of accepted matches; all-ones when none.
- busy  out  1  high in FIRE or HOLDOFF.

Behaviour:
- Reset values:
  - trigger=0, triggered=0, busy=0.
  - num_triggers=0, num_missed=0, min_score=all-ones.
  - State = IDLE.
- State machine:
  - IDLE: armed_and_ready=1 -> ARMED. sad_match ignored and not counted.
  - ARMED: sad_match=1 -> FIRE. trigger rises the next cycle: match at cycle N gives trigger=1 at N+1.
  - FIRE:
    - trigger held high for W = max(trig_width,1) cycles.
    - Width and holdoff are sampled on FIRE entry; later changes affect only the next trigger.
    - After W cycles: holdoff>0 -> HOLDOFF; holdoff=0 -> ARMED if multiple_triggers, else DONE.
  - HOLDOFF: count holdoff_cycles cycles, then -> ARMED if multiple_triggers, else DONE.
  - DONE: wait for armed_and_ready=0 -> IDLE.
- Accepted match is a transition from ARMED into FIRE. On acceptance:
  - triggered=1.
  - num_triggers += 1, saturating.
  - min_score = min(min_score, sad_score), unsigned compare.
- Back-to-back: a match arriving in the last HOLDOFF cycle is missed. A match in the first ARMED cycle is accepted.
  - Minimum spacing between trigger rising edges is W + holdoff + 1 cycles.
- Missed: sad_match=1 while in FIRE, HOLDOFF or DONE -> num_missed += 1, saturating.
- armed_and_ready=0 in any state:
  - Next state IDLE.
  - trigger forced 0 the next cycle; the pulse is truncated.
  - Holdoff is abandoned.
  - Status is retained.
- status_clear:
  - Clears triggered, num_triggers, num_missed and min_score (to all-ones) next cycle.
  - Does not change state.
  - Wins over a simultaneous increment or min update: the result is cleared.
- reset mid-operation: all outputs return to reset values next cycle, including trigger; state = IDLE.
- Counters never wrap: at all-ones they hold.

Decomposition:
- Package sad_trigger_pkg:
  - State encoding (IDLE, ARMED, FIRE, HOLDOFF, DONE).
  - Default widths.
  - Constant SCORE_NONE = all-ones.
- Sub-module sad_sat_counter:
  - Parameterized width.
  - Inputs: inc, clear (clear priority).
  - Instantiated for num_triggers and num_missed.

Test Plan:
- Basic fire:
  - Stimulus: armed=1, multiple_triggers=1, trig_width=1, holdoff=0, match at cycle 10 with score 37.
  - Required: trigger high only at cycle 11; num_triggers=1; triggered=1; min_score=37.
- Holdoff and missed:
  - Stimulus: trig_width=4, holdoff=8, matches at cycles 10, 14 and 23.
  - Required: pulse at cycles 11-14; holdoff 15-22; match at 14 missed; match at 23 accepted, pulse at 24; num_triggers=2; num_missed=1.
- Single mode:
  - Stimulus: multiple_triggers=0, three matches 50 cycles apart.
  - Required: one pulse only; num_missed=2. Then disarm/re-arm plus one match gives num_triggers=2.
- Disarm mid-pulse:
  - Stimulus: trig_width=10, armed_and_ready drops 3 cycles into the pulse.
  - Required: trigger=0 the following cycle; state IDLE; num_triggers retained at 1.
- Saturation and clear:
  - Stimulus: 300 accepted matches, then status_clear coinciding with an accepted match.
  - Required: num_triggers=255 before the clear; after it num_triggers=0, triggered=0, min_score=all-ones; trigger pulse still emitted.
- Reset mid-holdoff:
  - Stimulus: reset=1 for one cycle during HOLDOFF.
  - Required: next cycle busy=0, all status at reset values. A match 1 cycle after reset with armed high fires 2 cycles after reset: first via IDLE->ARMED, then accepted.
